// File: rtl/litepcie_usp_pkg.sv
// Shared definitions for the UltraScale+ PCIe PHY wrapper adapters:
// RC descriptor field layout, completion fmt/type codes and tuser bit indices.
package litepcie_usp_pkg;

    localparam int RC_LADDR_LSB  = 0;
    localparam int RC_LADDR_W    = 12;
    localparam int RC_ERR_LSB    = 12;
    localparam int RC_ERR_W      = 4;
    localparam int RC_BCNT_LSB   = 16;
    localparam int RC_BCNT_W     = 13;
    localparam int RC_LOCKED_BIT = 29;
    localparam int RC_DWCNT_LSB  = 32;
    localparam int RC_DWCNT_W    = 11;
    localparam int RC_STATUS_LSB = 43;
    localparam int RC_STATUS_W   = 3;
    localparam int RC_POISON_BIT = 46;
    localparam int RC_REQID_LSB  = 48;
    localparam int RC_TAG_LSB    = 64;
    localparam int RC_TAG_W      = 8;
    localparam int RC_CPLID_LSB  = 72;
    localparam int RC_TC_LSB     = 89;
    localparam int RC_TC_W       = 3;
    localparam int RC_ATTR_LSB   = 92;
    localparam int RC_ATTR_W     = 3;
    localparam int RC_DESC_W     = 96;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;
    localparam logic [4:0] TYPE_CPL_LK    = 5'b01011;

    localparam int RC_TUSER_W           = 75;
    localparam int RC_TUSER_DISCONTINUE = 42;

    // Rebuild a 3-DW Cpl/CplD/CplDLk header from the hard-block RC descriptor.
    function automatic logic [95:0] rc_desc_to_cpl_hdr(input logic [95:0] d);
        logic [10:0] dwcnt;
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
        dwcnt = d[RC_DWCNT_LSB +: RC_DWCNT_W];
        dw0 = '0;
        dw0[9:0]   = dwcnt[9:0];
        dw0[13:12] = d[RC_ATTR_LSB +: 2];
        dw0[14]    = d[RC_POISON_BIT];
        dw0[22:20] = d[RC_TC_LSB +: RC_TC_W];
        dw0[28:24] = d[RC_LOCKED_BIT] ? TYPE_CPL_LK : TYPE_CPL;
        dw0[31:29] = (dwcnt != '0) ? FMT_3DW_DATA : FMT_3DW_NODATA;
        dw1 = {d[RC_CPLID_LSB +: 16], d[RC_STATUS_LSB +: RC_STATUS_W], 1'b0,
               d[RC_BCNT_LSB +: 12]};
        dw2 = {d[RC_REQID_LSB +: 16], d[RC_TAG_LSB +: RC_TAG_W], 1'b0,
               d[RC_LADDR_LSB +: 7]};
        return {dw2, dw1, dw0};
    endfunction

    function automatic logic [31:0] dw_keep_to_byte_keep(input logic [7:0] k);
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = {4{k[i]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/m_axis_rc_adapt_if.sv
// RC completion stream bundle: hard-block side (*_a) and LitePCIe side.
interface m_axis_rc_adapt_if #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0]    m_axis_rc_tdata_a;
    logic [DATA_WIDTH/32-1:0] m_axis_rc_tkeep_a;
    logic                     m_axis_rc_tlast_a;
    logic [74:0]              m_axis_rc_tuser_a;
    logic                     m_axis_rc_tvalid_a;
    logic                     m_axis_rc_tready_a;

    logic [DATA_WIDTH-1:0]    m_axis_rc_tdata;
    logic [KEEP_WIDTH-1:0]    m_axis_rc_tkeep;
    logic                     m_axis_rc_tlast;
    logic [1:0]               m_axis_rc_tuser;
    logic                     m_axis_rc_tvalid;
    logic                     m_axis_rc_tready;

    modport slave (
        input  m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a,
               m_axis_rc_tuser_a, m_axis_rc_tvalid_a,
        output m_axis_rc_tready_a,
        output m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast,
               m_axis_rc_tuser, m_axis_rc_tvalid,
        input  m_axis_rc_tready
    );

    modport master (
        output m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a,
               m_axis_rc_tuser_a, m_axis_rc_tvalid_a,
        input  m_axis_rc_tready_a,
        input  m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast,
               m_axis_rc_tuser, m_axis_rc_tvalid,
        output m_axis_rc_tready
    );
endinterface

// File: rtl/rc_skid_buffer.sv
// Two-entry registered AXI-Stream skid buffer; ready and data are both registered.
module rc_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic             s_fire;
    logic             out_free;

    assign s_fire   = s_valid & s_ready;
    assign out_free = m_ready | ~m_valid;

    // s_ready mirrors an empty spare entry, so a beat in flight during a stall always fits.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (out_free) begin
            skid_valid_nxt = 1'b0;
        end else if (s_fire) begin
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            s_ready    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            s_ready    <= ~skid_valid_nxt;
            if (out_free) begin
                if (skid_valid) begin
                    m_data  <= skid_data;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= s_fire;
                    if (s_fire) begin
                        m_data <= s_data;
                    end
                end
            end else if (s_fire) begin
                skid_data <= s_data;
            end
        end
    end
endmodule

// File: rtl/m_axis_rc_adapt.sv
// RC completion adapter: rewrites the first-beat RC descriptor into a 3-DW Cpl header.
// Optional RC_ERR_CNT_EN builds a saturating completion-error counter on rc_err_cnt.
module m_axis_rc_adapt
    import litepcie_usp_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    m_axis_rc_adapt_if.slave      rc,
    output logic [15:0]           rc_err_cnt
);
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + 2;

    logic                  tfirst;
    logic                  in_fire;
    logic [RC_DESC_W-1:0]  desc;
    logic                  hdr_err;
    logic                  hdr_poison;
    logic [DATA_WIDTH-1:0] tdata_mod;
    logic [1:0]            tuser_mod;
    logic [PW-1:0]         s_payload;
    logic [PW-1:0]         m_payload;

    assign in_fire    = rc.m_axis_rc_tvalid_a & rc.m_axis_rc_tready_a;
    assign desc       = rc.m_axis_rc_tdata_a[RC_DESC_W-1:0];
    assign hdr_err    = desc[RC_ERR_LSB +: RC_ERR_W] != '0;
    assign hdr_poison = desc[RC_POISON_BIT];

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            tfirst <= 1'b1;
        end else if (in_fire) begin
            tfirst <= rc.m_axis_rc_tlast_a;
        end
    end

    always_comb begin
        tdata_mod = rc.m_axis_rc_tdata_a;
        tuser_mod = {1'b0, rc.m_axis_rc_tuser_a[RC_TUSER_DISCONTINUE]};
        if (tfirst) begin
            tdata_mod[RC_DESC_W-1:0] = rc_desc_to_cpl_hdr(desc);
            tuser_mod[1]             = hdr_err;
        end
    end

    assign s_payload = {tdata_mod, dw_keep_to_byte_keep(rc.m_axis_rc_tkeep_a),
                        rc.m_axis_rc_tlast_a, tuser_mod};

    rc_skid_buffer #(.WIDTH(PW)) u_skid (
        .clk     (user_clk),
        .rst_n   (user_reset_n),
        .s_data  (s_payload),
        .s_valid (rc.m_axis_rc_tvalid_a),
        .s_ready (rc.m_axis_rc_tready_a),
        .m_data  (m_payload),
        .m_valid (rc.m_axis_rc_tvalid),
        .m_ready (rc.m_axis_rc_tready)
    );

    assign {rc.m_axis_rc_tdata, rc.m_axis_rc_tkeep, rc.m_axis_rc_tlast,
            rc.m_axis_rc_tuser} = m_payload;

`ifdef RC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            err_cnt_q <= '0;
        end else if (in_fire && tfirst && (hdr_err || hdr_poison) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign rc_err_cnt = err_cnt_q;
`else
    assign rc_err_cnt = '0;
`endif

endmodule

// File: tb/tb_m_axis_rc_adapt.sv
// Self-checking bench for m_axis_rc_adapt: vector table, directed corner sequences
// and a randomized packet stream scored against a packet-level reference model.
`timescale 1ns/1ps
module tb_m_axis_rc_adapt;

    typedef struct {
        int unsigned la, err, bc, lk, dwc, st, ep, rid, tag, cid, tc, attr;
    } desc_t;

    typedef struct {
        desc_t       f;
        logic [7:0]  keep;
        logic        disc;
        logic [31:0] e_dw0, e_dw1, e_dw2, e_keep;
        logic [1:0]  e_user;
    } vec_t;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
        logic [1:0]   u;
    } beat_t;

    logic        user_clk;
    logic        user_reset_n;
    logic [15:0] rc_err_cnt;
    m_axis_rc_adapt_if rc_if ();

    m_axis_rc_adapt dut (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .rc           (rc_if),
        .rc_err_cnt   (rc_err_cnt)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    vec_t  vt[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic desc_t mk(int unsigned la, int unsigned err, int unsigned bc,
                                 int unsigned lk, int unsigned dwc, int unsigned st,
                                 int unsigned ep, int unsigned rid, int unsigned tag,
                                 int unsigned cid, int unsigned tc, int unsigned attr);
        desc_t f;
        f.la = la; f.err = err; f.bc = bc; f.lk = lk; f.dwc = dwc; f.st = st;
        f.ep = ep; f.rid = rid; f.tag = tag; f.cid = cid; f.tc = tc; f.attr = attr;
        return f;
    endfunction

    // Reserved descriptor bits get junk so the rewrite is shown to ignore them.
    function automatic logic [95:0] pack_desc(desc_t f, logic [4:0] rsv);
        logic [95:0] d;
        d = '0;
        d = d | 96'(f.la) | (96'(f.err) << 12) | (96'(f.bc) << 16) | (96'(f.lk) << 29)
              | (96'(f.dwc) << 32) | (96'(f.st) << 43) | (96'(f.ep) << 46)
              | (96'(f.rid) << 48) | (96'(f.tag) << 64) | (96'(f.cid) << 72)
              | (96'(f.tc) << 89) | (96'(f.attr) << 92);
        d[30] = rsv[0]; d[31] = rsv[1]; d[47] = rsv[2]; d[88] = rsv[3]; d[95] = rsv[4];
        return d;
    endfunction

    function automatic logic [95:0] cpl_hdr(desc_t f);
        int unsigned dw0, dw1, dw2;
        dw0 = ((f.dwc != 0) ? 32'h4000_0000 : 32'h0)
            + (f.lk != 0 ? 32'h0B00_0000 : 32'h0A00_0000)
            + (f.tc % 8) * 32'h10_0000 + f.ep * 32'h4000
            + (f.attr % 4) * 32'h1000 + (f.dwc % 1024);
        dw1 = f.cid * 32'h1_0000 + f.st * 32'h2000 + (f.bc % 4096);
        dw2 = f.rid * 32'h1_0000 + f.tag * 32'h100 + (f.la % 128);
        return {dw2, dw1, dw0};
    endfunction

    function automatic logic [31:0] expand_keep(logic [7:0] k);
        logic [31:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) if (k[i]) e = e | (32'hF << (4 * i));
        return e;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [74:0] rand75();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[74:0];
    endfunction

    function automatic desc_t rand_desc();
        return mk($urandom_range(0, 4095), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0,
                  $urandom_range(0, 8191), $urandom_range(0, 1), $urandom_range(0, 2047),
                  $urandom_range(0, 7), ($urandom_range(0, 4) == 0) ? 1 : 0,
                  $urandom_range(0, 65535), $urandom_range(0, 255), $urandom_range(0, 65535),
                  $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    function automatic void note_hdr(desc_t f);
`ifdef RC_ERR_CNT_EN
        if ((f.err != 0 || f.ep != 0) && exp_cnt < 65535) exp_cnt++;
`endif
    endfunction

    // Entered and left on a falling edge; leaves tvalid_a asserted for back-to-back use.
    task automatic send_beat(input logic [255:0] d, input logic [7:0] k, input logic l,
                             input logic [74:0] u);
        int n;
        rc_if.m_axis_rc_tdata_a  = d;
        rc_if.m_axis_rc_tkeep_a  = k;
        rc_if.m_axis_rc_tlast_a  = l;
        rc_if.m_axis_rc_tuser_a  = u;
        rc_if.m_axis_rc_tvalid_a = 1'b1;
        n = 0;
        while (rc_if.m_axis_rc_tready_a !== 1'b1 && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got tready_a=%b expected 1", rc_if.m_axis_rc_tready_a);
        end
        @(negedge user_clk);
    endtask

    task automatic idle(input int n);
        rc_if.m_axis_rc_tvalid_a = 1'b0;
        repeat (n) @(negedge user_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 256'(rc_if.m_axis_rc_tvalid), 256'(0));
        chk({tag, "_tready_a"}, 256'(rc_if.m_axis_rc_tready_a), 256'(0));
        chk({tag, "_tdata"}, rc_if.m_axis_rc_tdata, 256'(0));
        chk({tag, "_tkeep_tlast_tuser"},
            256'({rc_if.m_axis_rc_tkeep, rc_if.m_axis_rc_tlast, rc_if.m_axis_rc_tuser}), 256'(0));
        chk({tag, "_err_cnt"}, 256'(rc_err_cnt), 256'(0));
    endtask

    task automatic record_beat(input int cyc);
        beat_t b;
        b.d = rc_if.m_axis_rc_tdata;
        b.k = rc_if.m_axis_rc_tkeep;
        b.l = rc_if.m_axis_rc_tlast;
        b.u = rc_if.m_axis_rc_tuser;
        got_q.push_back(b);
        got_cyc.push_back(cyc);
    endtask

    task automatic chk_beat(input string name, input beat_t g, input beat_t e);
        chk({name, "_data"}, g.d, e.d);
        chk({name, "_keep_last_user"}, 256'({g.k, g.l, g.u}), 256'({e.k, e.l, e.u}));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [74:0]  u;
        beat_t        e;
        beat_t        pk[$];
        desc_t        f;
        bit           driver_done;

        vt[0] = '{mk('h10, 0, 4, 0, 1, 0, 0, 'h0100, 'h2A, 'h0200, 0, 0), 8'h0F, 1'b0,
                  32'h4A000001, 32'h02000004, 32'h01002A10, 32'h0000FFFF, 2'b00};
        vt[1] = '{mk('h44, 3, 8, 0, 0, 4, 0, 'h1234, 'h01, 'hABCD, 0, 0), 8'h01, 1'b0,
                  32'h0A000000, 32'hABCD8008, 32'h12340144, 32'h0000000F, 2'b10};
        vt[2] = '{mk('h87F, 0, 16, 1, 4, 0, 1, 'hFFFF, 'hFF, 'h0001, 5, 6), 8'hFF, 1'b1,
                  32'h4B506004, 32'h00010010, 32'hFFFFFF7F, 32'hFFFFFFFF, 2'b01};
        vt[3] = '{mk(0, 0, 4096, 0, 1024, 2, 0, 'h0001, 'h80, 'h0002, 0, 0), 8'hA5, 1'b0,
                  32'h4A000000, 32'h00024000, 32'h00018000, 32'hF0F00F0F, 2'b00};
        vt[4] = '{mk('hFFF, 15, 'h1FFF, 0, 2047, 7, 0, 'hAAAA, 'h55, 'h5555, 7, 7), 8'h80, 1'b1,
                  32'h4A7033FF, 32'h5555EFFF, 32'hAAAA557F, 32'hF0000000, 2'b11};

        user_reset_n             = 1'b0;
        rc_if.m_axis_rc_tvalid_a = 1'b0;
        rc_if.m_axis_rc_tdata_a  = '0;
        rc_if.m_axis_rc_tkeep_a  = '0;
        rc_if.m_axis_rc_tlast_a  = 1'b0;
        rc_if.m_axis_rc_tuser_a  = '0;
        rc_if.m_axis_rc_tready   = 1'b1;
        repeat (3) @(negedge user_clk);
        chk_reset_outputs("reset");
        user_reset_n = 1'b1;
        @(negedge user_clk);
        chk("ready_after_reset", 256'(rc_if.m_axis_rc_tready_a), 256'(1));

        // Vector table: single-beat completions, output checked one cycle after handshake.
        for (int i = 0; i < 5; i++) begin
            d = rand256();
            d[95:0] = pack_desc(vt[i].f, 5'($urandom));
            u = rand75();
            u[42] = vt[i].disc;
            note_hdr(vt[i].f);
            send_beat(d, vt[i].keep, 1'b1, u);
            rc_if.m_axis_rc_tvalid_a = 1'b0;
            chk($sformatf("vec%0d_tvalid", i), 256'(rc_if.m_axis_rc_tvalid), 256'(1));
            chk($sformatf("vec%0d_dw0", i), 256'(rc_if.m_axis_rc_tdata[31:0]), 256'(vt[i].e_dw0));
            chk($sformatf("vec%0d_dw1", i), 256'(rc_if.m_axis_rc_tdata[63:32]), 256'(vt[i].e_dw1));
            chk($sformatf("vec%0d_dw2", i), 256'(rc_if.m_axis_rc_tdata[95:64]), 256'(vt[i].e_dw2));
            chk($sformatf("vec%0d_upper", i), 256'(rc_if.m_axis_rc_tdata[255:96]), 256'(d[255:96]));
            chk($sformatf("vec%0d_tkeep", i), 256'(rc_if.m_axis_rc_tkeep), 256'(vt[i].e_keep));
            chk($sformatf("vec%0d_tuser", i), 256'(rc_if.m_axis_rc_tuser), 256'(vt[i].e_user));
            chk($sformatf("vec%0d_tlast", i), 256'(rc_if.m_axis_rc_tlast), 256'(1));
        end
        chk("err_cnt_after_table", 256'(rc_err_cnt), 256'(exp_cnt));

        // 3-beat CplD of 20 DW with tready held high.
        idle(2);
        pk.delete(); got_q.delete(); got_cyc.delete();
        f = mk('h20, 0, 80, 0, 20, 0, 0, 'h0100, 'h07, 'h0200, 0, 0);
        note_hdr(f);
        for (int b = 0; b < 3; b++) begin
            e.d = rand256();
            if (b == 0) e.d[95:0] = pack_desc(f, 5'($urandom));
            e.k = (b == 2) ? 32'h7F : 32'hFF;
            e.l = (b == 2);
            e.u = '0;
            pk.push_back(e);
        end
        fork
            begin
                for (int b = 0; b < 3; b++) send_beat(pk[b].d, pk[b].k[7:0], pk[b].l, '0);
                rc_if.m_axis_rc_tvalid_a = 1'b0;
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    @(negedge user_clk);
                    if (rc_if.m_axis_rc_tvalid) record_beat(c);
                end
            end
        join
        chk("cpld3_count", 256'(got_q.size()), 256'(3));
        if (got_q.size() == 3) begin
            chk("cpld3_consecutive", 256'(got_cyc[2] - got_cyc[0]), 256'(2));
            for (int b = 0; b < 3; b++) begin
                e.d = pk[b].d;
                if (b == 0) e.d[95:0] = cpl_hdr(f);
                e.k = expand_keep(pk[b].k[7:0]);
                e.l = pk[b].l;
                e.u = '0;
                chk_beat($sformatf("cpld3_beat%0d", b), got_q[b], e);
            end
        end

        // Backpressure: downstream ready low for three cycles mid-packet.
        idle(2);
        pk.delete(); got_q.delete(); got_cyc.delete();
        f = rand_desc();
        note_hdr(f);
        for (int b = 0; b < 6; b++) begin
            e.d = rand256();
            if (b == 0) e.d[95:0] = pack_desc(f, 5'($urandom));
            e.k = 32'($urandom_range(1, 255));
            e.l = (b == 5);
            e.u = '0;
            pk.push_back(e);
        end
        fork
            begin
                for (int b = 0; b < 6; b++) send_beat(pk[b].d, pk[b].k[7:0], pk[b].l, '0);
                rc_if.m_axis_rc_tvalid_a = 1'b0;
            end
            begin
                for (int c = 1; c <= 20; c++) begin
                    @(negedge user_clk);
                    if (c == 3) begin
                        chk("bp_ready_before_stall", 256'(rc_if.m_axis_rc_tready_a), 256'(1));
                        rc_if.m_axis_rc_tready = 1'b0;
                    end
                    if (c == 4) chk("bp_ready_falls", 256'(rc_if.m_axis_rc_tready_a), 256'(0));
                    if (c == 6) rc_if.m_axis_rc_tready = 1'b1;
                    if (rc_if.m_axis_rc_tvalid && rc_if.m_axis_rc_tready) record_beat(c);
                end
            end
        join
        chk("bp_count", 256'(got_q.size()), 256'(6));
        for (int b = 0; b < 6 && b < got_q.size(); b++) begin
            e.d = pk[b].d;
            e.u = '0;
            if (b == 0) begin
                e.d[95:0] = cpl_hdr(f);
                e.u[1] = (f.err != 0);
            end
            e.k = expand_keep(pk[b].k[7:0]);
            e.l = pk[b].l;
            chk_beat($sformatf("bp_beat%0d", b), got_q[b], e);
        end

        // Randomized packet stream against the reference model, random downstream stalls.
        idle(2);
        driver_done = 1'b0;
        exp_q.delete();
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int nb;
                    desc_t rf;
                    nb = $urandom_range(1, 4);
                    rf = rand_desc();
                    note_hdr(rf);
                    for (int b = 0; b < nb; b++) begin
                        logic [255:0] rd;
                        logic [7:0]   rk;
                        logic [74:0]  ru;
                        beat_t        re;
                        rd = rand256();
                        rk = 8'($urandom_range(1, 255));
                        ru = rand75();
                        re.u = {1'b0, ru[42]};
                        if (b == 0) begin
                            rd[95:0] = pack_desc(rf, 5'($urandom));
                            re.u[1]  = (rf.err != 0);
                        end
                        re.d = rd;
                        if (b == 0) re.d[95:0] = cpl_hdr(rf);
                        re.k = expand_keep(rk);
                        re.l = (b == nb - 1);
                        exp_q.push_back(re);
                        if ($urandom_range(0, 3) == 0) idle(1);
                        send_beat(rd, rk, re.l, ru);
                    end
                end
                rc_if.m_axis_rc_tvalid_a = 1'b0;
                driver_done = 1'b1;
            end
            begin
                int           cyc;
                bit           prev_stall;
                logic [255:0] prev_d;
                beat_t        g;
                cyc = 0;
                prev_stall = 1'b0;
                prev_d = '0;
                while (!(driver_done && exp_q.size() == 0) && cyc < 5000) begin
                    @(negedge user_clk);
                    cyc++;
                    if (prev_stall) begin
                        chk("rand_hold_valid", 256'(rc_if.m_axis_rc_tvalid), 256'(1));
                        chk("rand_hold_data", rc_if.m_axis_rc_tdata, prev_d);
                    end
                    rc_if.m_axis_rc_tready = ($urandom_range(0, 9) < 7);
                    if (rc_if.m_axis_rc_tvalid && rc_if.m_axis_rc_tready) begin
                        g.d = rc_if.m_axis_rc_tdata;
                        g.k = rc_if.m_axis_rc_tkeep;
                        g.l = rc_if.m_axis_rc_tlast;
                        g.u = rc_if.m_axis_rc_tuser;
                        if (exp_q.size() == 0) begin
                            chk("rand_unexpected_beat", 256'(1), 256'(0));
                        end else begin
                            chk_beat("rand", g, exp_q.pop_front());
                        end
                    end
                    prev_stall = rc_if.m_axis_rc_tvalid && !rc_if.m_axis_rc_tready;
                    prev_d = rc_if.m_axis_rc_tdata;
                end
                if (cyc >= 5000) chk("rand_drain_timeout", 256'(exp_q.size()), 256'(0));
                rc_if.m_axis_rc_tready = 1'b1;
            end
        join
        chk("rand_err_cnt", 256'(rc_err_cnt), 256'(exp_cnt));

        // Reset in the middle of a 3-beat packet with beats buffered.
        idle(2);
        rc_if.m_axis_rc_tready = 1'b0;
        f = rand_desc();
        d = rand256();
        d[95:0] = pack_desc(f, 5'($urandom));
        send_beat(d, 8'hFF, 1'b0, '0);
        send_beat(rand256(), 8'hFF, 1'b0, '0);
        rc_if.m_axis_rc_tvalid_a = 1'b0;
        user_reset_n = 1'b0;
        #1;
        chk_reset_outputs("midpkt_reset");
        exp_cnt = 0;
        @(negedge user_clk);
        rc_if.m_axis_rc_tready = 1'b1;
        user_reset_n = 1'b1;
        chk("midpkt_ready_low_at_release", 256'(rc_if.m_axis_rc_tready_a), 256'(0));
        @(negedge user_clk);
        chk("midpkt_ready_after_release", 256'(rc_if.m_axis_rc_tready_a), 256'(1));
        d = rand256();
        d[95:0] = pack_desc(vt[0].f, 5'($urandom));
        note_hdr(vt[0].f);
        send_beat(d, 8'h0F, 1'b0, '0);
        rc_if.m_axis_rc_tvalid_a = 1'b0;
        chk("midpkt_next_is_header", 256'(rc_if.m_axis_rc_tdata[95:0]), 256'(cpl_hdr(vt[0].f)));
        chk("midpkt_valid", 256'(rc_if.m_axis_rc_tvalid), 256'(1));
        send_beat(rand256(), 8'h01, 1'b1, '0);
        rc_if.m_axis_rc_tvalid_a = 1'b0;

        // Error completion with no payload: error counter steps 0 -> 1 when built.
        chk("errcpl_cnt_before", 256'(rc_err_cnt), 256'(0));
        f = mk('h08, 3, 0, 0, 0, 1, 0, 'h0042, 'h11, 'h0300, 0, 0);
        d = rand256();
        d[95:0] = pack_desc(f, 5'($urandom));
        note_hdr(f);
        send_beat(d, 8'h07, 1'b1, '0);
        rc_if.m_axis_rc_tvalid_a = 1'b0;
        chk("errcpl_fmt_type", 256'(rc_if.m_axis_rc_tdata[31:24]), 256'(8'h0A));
        chk("errcpl_tuser", 256'(rc_if.m_axis_rc_tuser), 256'(2'b10));
        chk("errcpl_cnt_after", 256'(rc_err_cnt), 256'(exp_cnt));

`ifdef RC_ERR_CNT_EN
        for (int i = 0; i < 65536; i++) begin
            note_hdr(f);
            send_beat(d, 8'h07, 1'b1, '0);
        end
        rc_if.m_axis_rc_tvalid_a = 1'b0;
        @(negedge user_clk);
        chk("errcnt_saturated", 256'(rc_err_cnt), 256'(16'hFFFF));
        chk("errcnt_model", 256'(rc_err_cnt), 256'(exp_cnt));
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_axis_rc_adapt.md
# m_axis_rc_adapt

Receive-path adapter between the UltraScale+ PCIe hard block's Requester Completion (RC) AXI-Stream interface and the LitePCIe completion-TLP stream. It rewrites the 96-bit RC completion descriptor on the first beat into a standard 3-DW Cpl/CplD header and expands the per-DW keep into byte keep. It registers the stream through a skid buffer, so both directions are fully registered. It is the RC-side counterpart of the RQ request adapter in the same PHY wrapper.

## Interface
- DATA_WIDTH, 256, data width in bits; only 256 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, output byte-keep width.
- user_clk  in  1  core user clock; all logic is on this clock.
- user_reset_n  in  1  asynchronous, active-low reset.
- m_axis_rc_tdata_a  in  256  RC data from the hard block.
- m_axis_rc_tkeep_a  in  8  per-DW keep.
- m_axis_rc_tlast_a  in  1  end of packet.
- m_axis_rc_tuser_a  in  75  RC sideband; bit 42 is discontinue, other bits are ignored.
- m_axis_rc_tvalid_a  in  1  input valid.
- m_axis_rc_tready_a  out  1  input ready; registered.
- m_axis_rc_tdata  out  256  TLP data to LitePCIe.
- m_axis_rc_tkeep  out  32  byte keep.
- m_axis_rc_tlast  out  1  end of packet.
- m_axis_rc_tuser  out  2  [0] discontinue, [1] completion error (descriptor error code != 0).
- m_axis_rc_tvalid  out  1  output valid.
- m_axis_rc_tready  in  1  downstream ready.
- rc_err_cnt  out  16  error count; meaningful only with RC_ERR_CNT_EN.

## Operation
- First-beat tracking: the `tfirst` flag is set at reset. On each input handshake it is cleared, then set again if tlast=1. The header rewrite applies only when tfirst=1.
- Descriptor fields on the first beat (input bits):
  - lower address [11:0]
  - error code [15:12]
  - byte count [28:16]
  - locked [29]
  - dword count [42:32]
  - status [45:43]
  - poisoned [46]
  - requester ID [63:48]
  - tag [71:64]
  - completer ID [87:72]
  - TC [91:89]
  - attr [94:92]
- Output header, first beat, tdata[95:0]:
  - DW0: length[9:0] = dword count[9:0] (a count of 1024 encodes as 0); attr[13:12] = attr[1:0]; EP[14] = poisoned; TD[15] = 0; TC[22:20]; type[28:24] = 01010, or 01011 when locked=1; fmt[31:29] = 010 when dword count != 0, else 000.
  - DW1: byte count[11:0] = byte count[11:0] (4096 encodes as 0); BCM[12] = 0; status[15:13]; completer ID[31:16].
  - DW2: lower address[6:0]; bit 7 = 0; tag[15:8]; requester ID[31:16].
- tdata[255:96] passes through unchanged on the first beat; the payload stays DW3-aligned. All later beats pass through unchanged.
- tkeep: each input keep bit i is replicated onto output byte-keep bits 4i+3..4i.
- tuser[0] = discontinue on every beat. tuser[1] = (error code != 0), first beat only, else 0.

## Timing
- Latency is one cycle from input handshake to output valid when the output is not stalled.
- Skid buffer holds two entries:
  - tready_a = 1 when the spare entry is empty, registered.
  - An output stall takes one cycle to reach tready_a; the spare entry absorbs the beat in flight.
  - Full throughput, one beat per cycle, is sustained while m_axis_rc_tready=1.
- Output beats are held stable while tvalid=1 and tready=0, as AXI-Stream requires.
- Reset values: m_axis_rc_tvalid=0, m_axis_rc_tready_a=0, tfirst=1, skid buffer empty, rc_err_cnt=0, all data outputs 0. tready_a rises on the first clock after reset deasserts.
- A single-beat packet (tfirst=1 and tlast=1) is rewritten, and tfirst stays 1 for the next beat.
- Back-to-back packets: a beat following a tlast beat is always treated as a header.
- Reset mid-packet: buffered beats are discarded and tfirst=1; the next input beat is parsed as a descriptor.

## Configuration
- RC_ERR_CNT_EN defined:
  - rc_err_cnt increments by 1 on each first-beat input handshake where error code != 0 or poisoned=1.
  - The counter saturates at 0xFFFF and clears only on reset.
- RC_ERR_CNT_EN undefined: rc_err_cnt is constant 0 and no counter logic is built.

## Structure
- Shared package `litepcie_usp_pkg` holds:
  - RC descriptor field offsets and widths.
  - Cpl/CplD/CplDLk fmt/type constants.
  - tuser bit indices (discontinue = 42).
- Sub-module `rc_skid_buffer`: a generic two-entry registered AXI-Stream skid buffer, parameterised on payload width. The header rewrite is combinational ahead of it.

## Test plan
- Single-beat CplD:
  - Stimulus: dword count=1, byte count=4, lower address=0x10, tag=0x2A, requester ID=0x0100, completer ID=0x0200, status=0, tkeep_a=0x0F, tlast=1.
  - Required output one cycle later: DW0=0x4A000001, DW1=0x02000004, DW2=0x01002A10, tkeep=0x0000FFFF, tuser=00.
- 3-beat CplD of 20 DW with m_axis_rc_tready held 1: 3 output beats on consecutive cycles; only beat 0 is rewritten; beats 1–2 are bit-identical to the input.
- Backpressure: drop m_axis_rc_tready for 3 cycles mid-packet. Required: tready_a falls one cycle later, no beat is lost or duplicated, and output order is preserved.
- Cpl with error code=0x3 and dword count=0: fmt=000, type=01010, tuser[1]=1. With RC_ERR_CNT_EN, rc_err_cnt goes 0→1. After 0x10000 such completions, rc_err_cnt reads 0xFFFF.
- Locked completion (bit 29=1) with poisoned=1: type=01011, EP=1.
- Assert user_reset_n=0 after beat 1 of a 3-beat packet. Required: outputs return to reset values; the next beat after release is rewritten as a header.
